// File: rtl/inequality_pkg.sv
// Shared constants, FSM state encoding and golden model for the 4-bit inequality classifier.
// Latency: n/a (package only).
// Backpressure: n/a.
package inequality_pkg;

  localparam int NUM_W = 4;
  localparam int OUT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Reference response: [2] num > 10, [1] num < 2, [0] 5 <= num <= 7.
  function automatic logic [OUT_W-1:0] ineq_expected(input logic [NUM_W-1:0] num);
    logic [OUT_W-1:0] e;
    e[2] = (num > 4'd10);
    e[1] = (num < 4'd2);
    e[0] = (num >= 4'd5) && (num <= 4'd7);
    return e;
  endfunction

endpackage

// File: rtl/inequality_golden.sv
// Combinational golden model of the inequality classifier (num_i -> exp_o).
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
// Ports: num_i stimulus value, exp_o expected classifier response.
module inequality_golden
  import inequality_pkg::*;
(
  input  logic [NUM_W-1:0] num_i,
  output logic [OUT_W-1:0] exp_o
);

  assign exp_o = ineq_expected(num_i);

endmodule

// File: rtl/inequality_sweep_checker.sv
// On-board self-check: sweeps NUM 0..15, holds each for SETTLE_CYCLES, compares OUT_DUT to the golden model.
// Latency: sample for value k at edge (k+1)*SETTLE_CYCLES after START; DONE the cycle after edge 16*SETTLE_CYCLES.
// Backpressure: none; START is ignored while a sweep is running.
// Ports: CLK/RST (sync, active-high), START level, OUT_DUT classifier response; NUM stimulus, BUSY, DONE pulse,
//        PASS, FAIL_CNT, FIRST_FAIL_VALID/FIRST_FAIL_NUM results, held until the next START or RST.
// Option: define SWEEP_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module inequality_sweep_checker
  import inequality_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [OUT_W-1:0] OUT_DUT,
  output logic [NUM_W-1:0] NUM,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [CNT_W-1:0] FAIL_CNT,
  output logic             FIRST_FAIL_VALID,
  output logic [NUM_W-1:0] FIRST_FAIL_NUM
);

  localparam logic [3:0]       SAMPLE_AT = 4'(SETTLE_CYCLES - 1);
  localparam logic [NUM_W-1:0] LAST_NUM  = {NUM_W{1'b1}};
  localparam logic [CNT_W-1:0] FAIL_MAX  = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic             ffv_q, ffv_d;
  logic [NUM_W-1:0] ffn_q, ffn_d;
  logic             pass_q, pass_d;

  logic [OUT_W-1:0] exp_w;
  logic             mismatch_w;
  logic             last_w;

  inequality_golden u_golden (
    .num_i (num_q),
    .exp_o (exp_w)
  );

  assign mismatch_w = (OUT_DUT != exp_w);

  // Decides whether the current sample edge ends the sweep.
`ifdef SWEEP_STOP_ON_FAIL_EN
  assign last_w = mismatch_w || (num_q == LAST_NUM);
`else
  assign last_w = (num_q == LAST_NUM);
`endif

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    ffv_d   = ffv_q;
    ffn_d   = ffn_q;
    pass_d  = pass_q;

    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = SETTLE;
          num_d   = '0;
          cnt_d   = '0;
          fail_d  = '0;
          ffv_d   = 1'b0;
          ffn_d   = '0;
          pass_d  = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt_q == SAMPLE_AT) begin
          cnt_d = '0;
          if (mismatch_w) begin
            // Saturate so the count can never wrap back to a passing value.
            if (fail_q != FAIL_MAX) fail_d = fail_q + 1'b1;
            if (!ffv_q) begin
              ffv_d = 1'b1;
              ffn_d = num_q;
            end
          end
          if (last_w) begin
            // NUM stays on the final (or failing) value after the sweep.
            state_d = FINISH;
            pass_d  = (fail_d == '0);
          end else begin
            num_d = num_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      num_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= '0;
      ffv_q   <= 1'b0;
      ffn_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      ffv_q   <= ffv_d;
      ffn_q   <= ffn_d;
      pass_q  <= pass_d;
    end
  end

  assign NUM              = num_q;
  assign BUSY             = (state_q == SETTLE);
  assign DONE             = (state_q == FINISH);
  assign PASS             = pass_q;
  assign FAIL_CNT         = fail_q;
  assign FIRST_FAIL_VALID = ffv_q;
  assign FIRST_FAIL_NUM   = ffn_q;

endmodule

// File: tb/tb_inequality_sweep_checker.sv
// Bench for inequality_sweep_checker with a behavioural classifier that can carry planted faults.
// Two instances: SETTLE_CYCLES=2 and SETTLE_CYCLES=1, sharing CLK/RST/START.
module tb_inequality_sweep_checker;

  typedef struct {
    int fail;
    int ffv;
    int ffn;
    int pass;
    int last;
    int done_edge;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  int         fault;
  int         sel;

  logic [3:0] num0, num1, ffn0, ffn1;
  logic [2:0] out0, out1;
  logic       busy0, busy1, done0, done1, pass0, pass1, ffv0, ffv1;
  logic [4:0] fcnt0, fcnt1;

  logic [3:0] m_num, m_ffn;
  logic       m_busy, m_done, m_pass, m_ffv;
  logic [4:0] m_fcnt;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  // Reference truth table of the classifier, written as a lookup.
  function automatic logic [2:0] gold(input int k);
    case (k)
      0, 1:               return 3'b010;
      5, 6, 7:            return 3'b001;
      11, 12, 13, 14, 15: return 3'b100;
      default:            return 3'b000;
    endcase
  endfunction

  // Classifier under test: 0 correct, 1 OUT[0] stuck at 1, 2 OUT[2] inverted at NUM=11.
  function automatic logic [2:0] cls(input logic [3:0] n, input int f);
    logic [2:0] r;
    r = gold(int'(n));
    if (f == 1) r[0] = 1'b1;
    if (f == 2 && n == 4'd11) r[2] = ~r[2];
    return r;
  endfunction

  assign out0 = cls(num0, fault);
  assign out1 = cls(num1, fault);

  inequality_sweep_checker #(.SETTLE_CYCLES(2), .CNT_W(5)) dut (
    .CLK(clk), .RST(rst), .START(start), .OUT_DUT(out0),
    .NUM(num0), .BUSY(busy0), .DONE(done0), .PASS(pass0), .FAIL_CNT(fcnt0),
    .FIRST_FAIL_VALID(ffv0), .FIRST_FAIL_NUM(ffn0)
  );

  inequality_sweep_checker #(.SETTLE_CYCLES(1), .CNT_W(5)) dut1 (
    .CLK(clk), .RST(rst), .START(start), .OUT_DUT(out1),
    .NUM(num1), .BUSY(busy1), .DONE(done1), .PASS(pass1), .FAIL_CNT(fcnt1),
    .FIRST_FAIL_VALID(ffv1), .FIRST_FAIL_NUM(ffn1)
  );

  assign m_num  = (sel != 0) ? num1  : num0;
  assign m_busy = (sel != 0) ? busy1 : busy0;
  assign m_done = (sel != 0) ? done1 : done0;
  assign m_pass = (sel != 0) ? pass1 : pass0;
  assign m_fcnt = (sel != 0) ? fcnt1 : fcnt0;
  assign m_ffv  = (sel != 0) ? ffv1  : ffv0;
  assign m_ffn  = (sel != 0) ? ffn1  : ffn0;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  function automatic exp_t model(input int f, input int s);
    exp_t e;
    e.fail = 0; e.ffv = 0; e.ffn = 0; e.last = 15;
    for (int k = 0; k < 16; k++) begin
      if (cls(4'(k), f) != gold(k)) begin
        e.fail++;
        if (e.ffv == 0) begin
          e.ffv = 1;
          e.ffn = k;
        end
`ifdef SWEEP_STOP_ON_FAIL_EN
        e.last = k;
        break;
`endif
      end
    end
    e.pass      = (e.fail == 0) ? 1 : 0;
    e.done_edge = (e.last + 1) * s;
    return e;
  endfunction

  task automatic reset_checks(input string tag);
    check({tag, "_num"},  int'(m_num),  0);
    check({tag, "_busy"}, int'(m_busy), 0);
    check({tag, "_done"}, int'(m_done), 0);
    check({tag, "_pass"}, int'(m_pass), 0);
    check({tag, "_fcnt"}, int'(m_fcnt), 0);
    check({tag, "_ffv"},  int'(m_ffv),  0);
    check({tag, "_ffn"},  int'(m_ffn),  0);
  endtask

  // Runs one sweep on the selected instance; repulse_n > 0 re-asserts START at that edge.
  task automatic run_sweep(input string tag, input int which, input int f, input int repulse_n);
    exp_t e, got;
    int   s, n, extra;
    bit   seen;
    sel   = which;
    fault = f;
    s     = (which != 0) ? 1 : 2;
    @(negedge clk);
    start = 1'b1;
    sb.push_back(model(f, s));
    e    = sb[$];
    n    = 0;
    seen = 0;
    while (n < 200) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 0) start = 1'b0;
      if (repulse_n > 0) start = (n == repulse_n);
      if (m_done) begin
        seen = 1;
        break;
      end
      check({tag, "_num"},  int'(m_num), (n / s < e.last) ? n / s : e.last);
      check({tag, "_busy"}, int'(m_busy), 1);
      n++;
    end
    start = 1'b0;
    if (!seen) begin
      check({tag, "_done_timeout"}, 0, 1);
      void'(sb.pop_front());
    end else begin
      got = sb.pop_front();
      check({tag, "_done_edge"}, n, got.done_edge);
      check({tag, "_done_busy"}, int'(m_busy), 0);
      check({tag, "_pass"},      int'(m_pass), got.pass);
      check({tag, "_fcnt"},      int'(m_fcnt), got.fail);
      check({tag, "_ffv"},       int'(m_ffv),  got.ffv);
      check({tag, "_ffn"},       int'(m_ffn),  got.ffn);
      @(negedge clk);
      check({tag, "_done_pulse"}, int'(m_done), 0);
      check({tag, "_num_hold"},   int'(m_num),  got.last);
      check({tag, "_fcnt_hold"},  int'(m_fcnt), got.fail);
      check({tag, "_pass_hold"},  int'(m_pass), got.pass);
      extra = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (m_done) extra++;
      end
      check({tag, "_extra_done"}, extra, 0);
    end
  endtask

  initial begin
    int n, dcount;
    rst   = 1'b1;
    start = 1'b0;
    fault = 0;
    sel   = 0;
    repeat (3) @(negedge clk);
    reset_checks("rst0");
    sel = 1;
    reset_checks("rst1");
    rst = 1'b0;

    run_sweep("clean", 0, 0, 0);
    run_sweep("stuck0", 0, 1, 0);
    run_sweep("inv11", 0, 2, 0);

    // Abort mid-sweep: RST high at edge 10 after the START edge.
    sel   = 0;
    fault = 1;
    @(negedge clk);
    start = 1'b1;
    n = 0;
    while (n < 10) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    reset_checks("midrst");
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done0) dcount++;
    end
    check("midrst_no_done", dcount, 0);

    run_sweep("after_rst", 0, 0, 0);
    run_sweep("repulse", 0, 0, 10);
    run_sweep("settle1", 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
